// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits.
// One byte per valid/ready handshake; serial line is fully registered.
module uart_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in_tx,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       data_out,
    output logic       busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = (STOP_BITS == 2);
    localparam logic        HAS_PAR   = (PARITY_EN != 0);

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic        stop_cnt;
    logic [7:0]  shreg;
    logic        par;
    logic        bit_end;

    assign bit_end = (cnt == BIT_LAST);

    // Ready must read low for the whole reset window, not just after the first edge.
    assign tx_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            idx      <= 3'd0;
            stop_cnt <= 1'b0;
            shreg    <= 8'd0;
            par      <= 1'b0;
            data_out <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    data_out <= 1'b1;
                    busy     <= 1'b0;
                    cnt      <= 16'd0;
                    if (tx_valid) begin
                        shreg    <= data_in_tx;
                        par      <= ^data_in_tx;
                        state    <= START;
                        data_out <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt      <= 16'd0;
                        idx      <= 3'd0;
                        state    <= DATA;
                        data_out <= shreg[0];
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= 16'd0;
                        if (idx == 3'd7) begin
                            stop_cnt <= 1'b0;
                            if (HAS_PAR) begin
                                state    <= PARITY;
                                data_out <= par;
                            end else begin
                                state    <= STOP;
                                data_out <= 1'b1;
                            end
                        end else begin
                            shreg    <= shreg >> 1;
                            data_out <= shreg[1];
                            idx      <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt      <= 16'd0;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                        data_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= 16'd0;
                        if (stop_cnt == STOP_LAST) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            tx_done  <= 1'b1;
                            data_out <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
